// File: rtl/pe_config_loader.sv
// -----------------------------------------------------------------------------
// pe_config_loader
//
// Transmitter side of the CGRA configuration-load interface. A session is
// opened with load_start, which latches the word count and the highest context
// slot in use. Each context word accepted on the input stream is presented one
// cycle later on the shared config_* bus, together with a one-hot strobe that
// selects the target PE. Once the last word has been sent, a single start_exec
// pulse is broadcast to all PEs.
//
// Words that target a non-existent PE or a context slot beyond the latched
// maximum are still consumed and counted toward the session length. They raise
// the sticky error flag and the saturating error_count, and they never strobe
// a PE.
//
// Ports:
//   clk, reset_n            clock; asynchronous active-low reset
//   load_start, load_abort  session open / abandon
//   load_word_count         words in the session (latched on load_start)
//   context_max_id          highest context slot (latched on load_start)
//   in_valid / in_ready     input word handshake
//   in_*                    input word fields (PE id, slot, operands, op, const)
//   write_config_data       one-hot per-PE write strobe
//   config_*                shared configuration bus
//   start_exec              one-cycle execution start pulse
//   mapping_context_max_id  latched context_max_id
//   busy, error, error_count  status
// -----------------------------------------------------------------------------
module pe_config_loader #(
    parameter int PE_NUM                     = 16,
    parameter int PE_ID_WIDTH                = 4,
    parameter int DATA_WIDTH                 = 32,
    parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 2,
    parameter int OPERATION_BIT_LENGTH       = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH    = 3,
    parameter int WORD_COUNT_WIDTH           = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  load_start,
    input  logic                                  load_abort,
    input  logic [WORD_COUNT_WIDTH-1:0]           load_word_count,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    context_max_id,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PE_ID_WIDTH-1:0]                in_pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    in_context_index,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in_input_PE_index_1,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in_input_PE_index_2,
    input  logic [OPERATION_BIT_LENGTH-1:0]       in_op,
    input  logic [DATA_WIDTH-1:0]                 in_const_data,
    output logic [PE_NUM-1:0]                     write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
    output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
    output logic [DATA_WIDTH-1:0]                 config_const_data,
    output logic                                  start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
    output logic                                  busy,
    output logic                                  error,
    output logic [WORD_COUNT_WIDTH-1:0]           error_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        START = 2'd3
    } state_t;

    // One extra bit, so that the PE limit can be represented even when
    // PE_NUM == 2**PE_ID_WIDTH.
    localparam logic [PE_ID_WIDTH:0] PE_LIMIT = (PE_ID_WIDTH + 1)'(PE_NUM);

    state_t                      state;
    state_t                      state_next;
    logic [WORD_COUNT_WIDTH-1:0] word_count_q;
    logic [WORD_COUNT_WIDTH-1:0] accepted_q;
    logic                        accept;
    logic                        word_ok;
    logic                        last_accept;
    logic [PE_NUM-1:0]           strobe_next;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;

    // The slot check uses the value latched at load_start, not the live input.
    assign word_ok = ({1'b0, in_pe_id} < PE_LIMIT) &&
                     (in_context_index <= mapping_context_max_id);

    // Rejected words still count toward the session length.
    assign last_accept = accept &&
                         ((accepted_q + WORD_COUNT_WIDTH'(1)) == word_count_q);

    // NOTE: state and every other register use non-blocking assignments only,
    // so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each variable written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (load_start) state_next = (load_word_count == '0) ? FLUSH : LOAD;
            LOAD:  begin
                // An abort wins over completion of the session.
                if (load_abort)       state_next = IDLE;
                else if (last_accept) state_next = FLUSH;
            end
            FLUSH: state_next = load_abort ? IDLE : START;
            START: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        strobe_next = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            if (accept && word_ok && (in_pe_id == PE_ID_WIDTH'(i))) begin
                strobe_next[i] = 1'b1;
            end
        end
    end

    // Registered outputs. start_exec and busy are decoded from the next state,
    // so they line up with the state register without adding a cycle of delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_config_data       <= '0;
            config_index            <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
            start_exec              <= 1'b0;
            busy                    <= 1'b0;
            mapping_context_max_id  <= '0;
            error                   <= 1'b0;
            error_count             <= '0;
            word_count_q            <= '0;
            accepted_q              <= '0;
        end else begin
            write_config_data <= strobe_next;
            start_exec        <= (state_next == START);
            busy              <= (state_next != IDLE);

            // The bus holds the last good word and changes only when a word
            // is written to a PE.
            if (accept && word_ok) begin
                config_index            <= in_context_index;
                config_input_PE_index_1 <= in_input_PE_index_1;
                config_input_PE_index_2 <= in_input_PE_index_2;
                config_op               <= in_op;
                config_const_data       <= in_const_data;
            end

            if (state == IDLE && load_start) begin
                word_count_q           <= load_word_count;
                mapping_context_max_id <= context_max_id;
                error                  <= 1'b0;
                error_count            <= '0;
                accepted_q             <= '0;
            end else if (accept) begin
                accepted_q <= accepted_q + WORD_COUNT_WIDTH'(1);
                if (!word_ok) begin
                    error <= 1'b1;
                    if (error_count != '1) begin
                        error_count <= error_count + WORD_COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// -----------------------------------------------------------------------------
// tb_pe_config_loader
//
// Directed stimulus with hand-computed expectations. Every accepted good word
// pushes its expected strobe (PE mask, bus contents, cycle) into exp_q, and
// every session that should complete pushes its expected start_exec cycle into
// start_q. A monitor on the falling edge pops and compares whenever the DUT
// presents a strobe or a start_exec pulse.
// -----------------------------------------------------------------------------
module tb_pe_config_loader;

    localparam int PE_NUM = 16;
    localparam int PE_IDW = 5;

    logic        clk;
    logic        reset_n;
    logic        load_start;
    logic        load_abort;
    logic [15:0] load_word_count;
    logic [2:0]  context_max_id;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_pe_id;
    logic [2:0]  in_context_index;
    logic [1:0]  in_input_PE_index_1;
    logic [1:0]  in_input_PE_index_2;
    logic [3:0]  in_op;
    logic [31:0] in_const_data;
    logic [15:0] write_config_data;
    logic [2:0]  config_index;
    logic [1:0]  config_input_PE_index_1;
    logic [1:0]  config_input_PE_index_2;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic        start_exec;
    logic [2:0]  mapping_context_max_id;
    logic        busy;
    logic        error;
    logic [15:0] error_count;

    typedef struct {
        logic [15:0] mask;
        logic [2:0]  ctx;
        logic [1:0]  i1;
        logic [1:0]  i2;
        logic [3:0]  op;
        logic [31:0] cdata;
        int          cyc;
    } strobe_t;

    strobe_t exp_q[$];
    int      start_q[$];
    strobe_t mon_e;
    int      mon_s;
    int      cyc = 0;
    int      n_vec = 0;
    int      n_err = 0;

    pe_config_loader #(
        .PE_NUM      (PE_NUM),
        .PE_ID_WIDTH (PE_IDW)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .load_start              (load_start),
        .load_abort              (load_abort),
        .load_word_count         (load_word_count),
        .context_max_id          (context_max_id),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_pe_id                (in_pe_id),
        .in_context_index        (in_context_index),
        .in_input_PE_index_1     (in_input_PE_index_1),
        .in_input_PE_index_2     (in_input_PE_index_2),
        .in_op                   (in_op),
        .in_const_data           (in_const_data),
        .write_config_data       (write_config_data),
        .config_index            (config_index),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .busy                    (busy),
        .error                   (error),
        .error_count             (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every strobe and start_exec against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (write_config_data != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(write_config_data), 64'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_mask",  64'(write_config_data),       64'(mon_e.mask));
                    check("strobe_cycle", 64'(cyc),                     64'(mon_e.cyc));
                    check("bus_index",    64'(config_index),            64'(mon_e.ctx));
                    check("bus_in1",      64'(config_input_PE_index_1), 64'(mon_e.i1));
                    check("bus_in2",      64'(config_input_PE_index_2), 64'(mon_e.i2));
                    check("bus_op",       64'(config_op),               64'(mon_e.op));
                    check("bus_const",    64'(config_const_data),       64'(mon_e.cdata));
                end
            end
            if (start_exec) begin
                if (start_q.size() == 0) begin
                    check("unexpected_start_exec", 64'(start_exec), 64'h0);
                end else begin
                    mon_s = start_q.pop_front();
                    check("start_exec_cycle", 64'(cyc), 64'(mon_s));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic start_session(input logic [15:0] n, input logic [2:0] m);
        load_start      = 1'b1;
        load_word_count = n;
        context_max_id  = m;
        tick();
        load_start = 1'b0;
        check("mapping_context_max_id", 64'(mapping_context_max_id), 64'(m));
        check("error_cleared",          64'(error),                  64'h0);
        check("error_count_cleared",    64'(error_count),            64'h0);
        check("busy_after_start",       64'(busy),                   64'h1);
        check("in_ready_after_start",   64'(in_ready),               64'(n != 0));
        if (n == 0) start_q.push_back(cyc + 1);
    endtask

    // Offers one word; ok = expect a strobe, last = expect start_exec after it.
    task automatic send_word(input logic [4:0] pe, input logic [2:0] ctx,
                             input logic [1:0] i1, input logic [1:0] i2,
                             input logic [3:0] op, input logic [31:0] c,
                             input bit ok, input bit last);
        bit          taken;
        logic [15:0] m;
        strobe_t     e;
        taken               = 1'b0;
        in_valid            = 1'b1;
        in_pe_id            = pe;
        in_context_index    = ctx;
        in_input_PE_index_1 = i1;
        in_input_PE_index_2 = i2;
        in_op               = op;
        in_const_data       = c;
        for (int k = 0; k < 20 && !taken; k++) begin
            taken = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("word_accepted", 64'(taken), 64'h1);
        if (taken && ok) begin
            m = 16'h0001 << pe[3:0];
            e = '{mask: m, ctx: ctx, i1: i1, i2: i2, op: op, cdata: c, cyc: cyc};
            exp_q.push_back(e);
        end
        if (taken && last) start_q.push_back(cyc + 1);
    endtask

    initial begin
        reset_n             = 1'b0;
        load_start          = 1'b0;
        load_abort          = 1'b0;
        load_word_count     = '0;
        context_max_id      = '0;
        in_valid            = 1'b0;
        in_pe_id            = '0;
        in_context_index    = '0;
        in_input_PE_index_1 = '0;
        in_input_PE_index_2 = '0;
        in_op               = '0;
        in_const_data       = '0;

        // Reset state
        #12;
        check("rst_in_ready",   64'(in_ready),          64'h0);
        check("rst_strobe",     64'(write_config_data), 64'h0);
        check("rst_start_exec", 64'(start_exec),        64'h0);
        check("rst_busy",       64'(busy),              64'h0);
        check("rst_error",      64'(error),             64'h0);
        check("rst_error_cnt",  64'(error_count),       64'h0);
        check("rst_max_id",     64'(mapping_context_max_id), 64'h0);
        reset_n = 1'b1;
        tick();

        // Back-to-back words: strobes 0x0001, 0x0020, 0x8000
        start_session(16'd3, 3'd2);
        send_word(5'd0,  3'd0, 2'd1, 2'd2, 4'd1, 32'h0000_0011, 1'b1, 1'b0);
        send_word(5'd5,  3'd1, 2'd3, 2'd0, 4'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        send_word(5'd15, 3'd2, 2'd2, 2'd1, 4'd8, 32'h8000_0001, 1'b1, 1'b1);
        check("t1_error", 64'(error), 64'h0);
        idle(4);
        check("t1_max_id_held", 64'(mapping_context_max_id), 64'h2);
        check("t1_idle_busy",   64'(busy),                   64'h0);

        // Gapped words: no strobe between accepts and the bus holds
        start_session(16'd2, 3'd1);
        send_word(5'd7, 3'd1, 2'd1, 2'd1, 4'd3, 32'h0000_A5A5, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gap_no_strobe",  64'(write_config_data), 64'h0);
            check("gap_op_hold",    64'(config_op),         64'h3);
            check("gap_const_hold", 64'(config_const_data), 64'hA5A5);
            check("gap_ready",      64'(in_ready),          64'h1);
        end
        send_word(5'd2, 3'd0, 2'd0, 2'd3, 4'hC, 32'h0000_1234, 1'b1, 1'b1);
        idle(4);

        // Zero-length session: no in_ready, start_exec two cycles later
        start_session(16'd0, 3'd5);
        tick();
        check("zero_in_ready", 64'(in_ready), 64'h0);
        idle(3);
        check("zero_max_id", 64'(mapping_context_max_id), 64'h5);

        // Rejected words: PE id out of range, then slot above max
        start_session(16'd3, 3'd2);
        send_word(5'd3,  3'd0, 2'd0, 2'd1, 4'd2, 32'h0000_0003, 1'b1, 1'b0);
        send_word(5'd16, 3'd0, 2'd1, 2'd1, 4'd4, 32'h0000_0016, 1'b0, 1'b0);
        send_word(5'd1,  3'd3, 2'd2, 2'd2, 4'd6, 32'h0000_0033, 1'b0, 1'b1);
        check("rej_error",       64'(error),       64'h1);
        check("rej_error_count", 64'(error_count), 64'h2);
        check("rej_bus_hold",    64'(config_op),   64'h2);
        idle(4);
        check("rej_error_sticky", 64'(error), 64'h1);
        start_session(16'd1, 3'd2);
        send_word(5'd9, 3'd2, 2'd3, 2'd3, 4'd7, 32'h0000_0999, 1'b1, 1'b1);
        idle(4);

        // Abort after 1 of 4 words
        start_session(16'd4, 3'd3);
        send_word(5'd4, 3'd3, 2'd1, 2'd0, 4'd9, 32'h0000_0004, 1'b1, 1'b0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        check("abort_busy",     64'(busy),     64'h0);
        check("abort_in_ready", 64'(in_ready), 64'h0);
        idle(3);

        // Abort in the same cycle as the final word: strobe issues, no start
        start_session(16'd2, 3'd3);
        send_word(5'd6, 3'd1, 2'd0, 2'd2, 4'hA, 32'h0000_0006, 1'b1, 1'b0);
        load_abort = 1'b1;
        send_word(5'd11, 3'd2, 2'd2, 2'd0, 4'hB, 32'h0000_000B, 1'b1, 1'b0);
        load_abort = 1'b0;
        check("abort_last_busy",     64'(busy),     64'h0);
        check("abort_last_in_ready", 64'(in_ready), 64'h0);
        idle(4);

        // A normal session after the aborts
        start_session(16'd1, 3'd0);
        send_word(5'd0, 3'd0, 2'd3, 2'd1, 4'hF, 32'hFFFF_0000, 1'b1, 1'b1);
        idle(4);

        // Reset in the middle of a session, right after a strobe appears
        start_session(16'd2, 3'd1);
        in_valid         = 1'b1;
        in_pe_id         = 5'd8;
        in_context_index = 3'd1;
        in_op            = 4'd2;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        in_valid = 1'b0;
        check("mid_rst_strobe",   64'(write_config_data),      64'h0);
        check("mid_rst_in_ready", 64'(in_ready),               64'h0);
        check("mid_rst_busy",     64'(busy),                   64'h0);
        check("mid_rst_start",    64'(start_exec),             64'h0);
        check("mid_rst_max_id",   64'(mapping_context_max_id), 64'h0);
        #4;
        reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'h0);
        check("post_rst_busy",     64'(busy),     64'h0);
        idle(3);

        check("strobes_outstanding", 64'(exp_q.size()),   64'h0);
        check("starts_outstanding",  64'(start_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_config_loader.md
Name: pe_config_loader

Overview:
- Drives the configuration-load interface of every PE in the CGRA array; it is the transmitter for the PEs' config receivers.
- Accepts a stream of context words, each tagged with a target PE id and a context slot.
- Issues a one-cycle per-PE write strobe on a shared config bus for each valid word.
- After the last word, pulses start_exec to all PEs and drives mapping_context_max_id.

Parameters:
- PE_NUM, 16, number of PEs driven (one write strobe each)
- PE_ID_WIDTH, 4, width of PE id field; must satisfy 2**PE_ID_WIDTH >= PE_NUM
- DATA_WIDTH, 32, const_data width
- NEIGHBOR_PE_NUM_BIT_LENGTH, 2, width of input PE index fields
- OPERATION_BIT_LENGTH, 4, opcode width
- CONTEXT_SIZE_BIT_LENGTH, 3, context index width
- WORD_COUNT_WIDTH, 16, width of word counter

Ports:
- clk  in  1  clock; one clock for the block
- reset_n  in  1  reset; asynchronous, active-low
- load_start  in  1  pulse; begin a load session (sampled in IDLE only)
- load_abort  in  1  abandon the session; return to IDLE without start_exec
- load_word_count  in  WORD_COUNT_WIDTH  number of words in the session, latched on load_start
- context_max_id  in  CONTEXT_SIZE_BIT_LENGTH  highest context used, latched on load_start
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word ready
- in_pe_id  in  PE_ID_WIDTH  target PE
- in_context_index  in  CONTEXT_SIZE_BIT_LENGTH  target context slot
- in_input_PE_index_1  in  NEIGHBOR_PE_NUM_BIT_LENGTH  operand 1 source
- in_input_PE_index_2  in  NEIGHBOR_PE_NUM_BIT_LENGTH  operand 2 source
- in_op  in  OPERATION_BIT_LENGTH  opcode
- in_const_data  in  DATA_WIDTH  constant
- write_config_data  out  PE_NUM  one-hot per-PE write strobe
- config_index  out  CONTEXT_SIZE_BIT_LENGTH  shared bus
- config_input_PE_index_1  out  NEIGHBOR_PE_NUM_BIT_LENGTH  shared bus
- config_input_PE_index_2  out  NEIGHBOR_PE_NUM_BIT_LENGTH  shared bus
- config_op  out  OPERATION_BIT_LENGTH  shared bus
- config_const_data  out  DATA_WIDTH  shared bus
- start_exec  out  1  one-cycle broadcast pulse
- mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  held stable from load_start until next load_start
- busy  out  1  high whenever state != IDLE
- error  out  1  sticky; cleared by an accepted load_start
- error_count  out  WORD_COUNT_WIDTH  rejected words this session; saturating

Behaviour:
- Reset (async, reset_n low): state IDLE; every output 0, including in_ready, write_config_data, start_exec, error and error_count; internal counters 0.
- States: IDLE, LOAD, FLUSH, START. All outputs are registered.
- IDLE:
  - load_start=1 latches load_word_count and context_max_id; mapping_context_max_id updates next cycle; error and error_count clear.
  - Next state is LOAD, or FLUSH if load_word_count==0.
- LOAD:
  - in_ready=1 (combinational from state).
  - A word is accepted on a cycle with in_valid&&in_ready.
  - Cycle after acceptance: config_* buses carry the word and write_config_data[in_pe_id]=1 for exactly one cycle.
  - Back-to-back accepts give one write per cycle. With no accept, write_config_data=0 and the buses hold their last value.
  - Rejection rule: a word with in_pe_id>=PE_NUM or in_context_index>latched context_max_id is consumed and counted, produces no strobe, sets error and increments error_count (saturating).
  - After the accept that reaches the latched count: in_ready drops the next cycle and state goes to FLUSH (that cycle carries the last strobe).
- FLUSH: one cycle, no strobe; then START.
- START: start_exec=1 for one cycle; next state IDLE.
- Timing: last accept at cycle t gives start_exec at t+2, with its strobe at t+1.
- load_abort:
  - In LOAD/FLUSH, returns to IDLE next cycle; in_ready=0 next cycle; no start_exec.
  - A strobe for a word accepted in the same cycle as the abort still issues.
  - load_abort has priority over completion.
  - Ignored in IDLE and START.
- load_start outside IDLE is ignored.
- in_valid in IDLE/FLUSH/START is not accepted.
- Reset mid-session: immediate IDLE, all strobes and start_exec deasserted asynchronously.

Test Plan:
- load_start with count=3, max_id=2; words (pe 0, ctx 0, op 1), (pe 5, ctx 1, op 5, const 0xDEADBEEF), (pe 15, ctx 2, op 8) back-to-back -> write_config_data = 0x0001, 0x0020, 0x8000 on consecutive cycles; start_exec exactly 2 cycles after the 3rd accept; mapping_context_max_id=2; error=0.
- count=2 with in_valid gapped by 3 idle cycles -> strobes only on cycles after accepts; buses hold between; start_exec once.
- count=0 -> no in_ready, no strobe; start_exec 2 cycles after load_start.
- count=3, middle word in_pe_id=16 with PE_NUM=16 (PE_ID_WIDTH=5), then ctx=3 with max_id=2 -> both consumed with no strobe; error=1; error_count=2; start_exec still issued; next load_start clears error.
- load_abort after 1 of 4 words -> 1 strobe, no start_exec, busy=0 next cycle; a later load_start is accepted normally.
- reset_n low during LOAD -> all outputs 0 asynchronously; after release, state IDLE and in_ready=0.
